// File: rtl/buff_uart_arbiter.sv
// Round-robin arbiter sharing the buffered UART register port among NUM_REQ requesters.
// Define BUFF_UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module buff_uart_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [WIDTH-1:0]                 rdata,
  output logic                             busy,
  output logic                             read_enable,
  output logic                             write_enable,
  output logic [ADDRESS_WIDTH-1:0]         active_address,
  output logic [WIDTH-1:0]                 data_in,
  input  logic [WIDTH-1:0]                 data_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD
  } state_e;

  state_e                     state_q;
  logic [IDX_W-1:0]           win_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_REQ-1:0]         gnt_q;
  logic [NUM_REQ-1:0]         rvalid_q;
  logic [WIDTH-1:0]           rdata_q;
  logic                       busy_q;
  logic                       read_enable_q;
  logic                       write_enable_q;
  logic [ADDRESS_WIDTH-1:0]   active_address_q;
  logic [WIDTH-1:0]           data_in_q;

  logic                       found_c;
  logic [IDX_W-1:0]           win_c;
  logic                       sel_we_c;
  logic [ADDRESS_WIDTH-1:0]   sel_addr_c;
  logic [WIDTH-1:0]           sel_wdata_c;

`ifdef BUFF_UART_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_c && req[IDX_W'(i)]) begin
        found_c = 1'b1;
        win_c   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_q;
  int unsigned      cand_c;

  // Search starts one past the last grant and wraps.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = (32'(last_q) + i) % NUM_REQ;
      if (!found_c && req[IDX_W'(cand_c)]) begin
        found_c = 1'b1;
        win_c   = IDX_W'(cand_c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (state_q == ST_IDLE && found_c) begin
      last_q <= win_c;
    end
  end
`endif

  // Route the winner's payload slice.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_c == IDX_W'(i)) begin
        sel_we_c    = req_we[i];
        sel_addr_c  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_wdata_c = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      win_q            <= '0;
      cnt_q            <= '0;
      gnt_q            <= '0;
      rvalid_q         <= '0;
      rdata_q          <= '0;
      busy_q           <= 1'b0;
      read_enable_q    <= 1'b0;
      write_enable_q   <= 1'b0;
      active_address_q <= '0;
      data_in_q        <= '0;
    end else begin
      gnt_q          <= '0;
      rvalid_q       <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found_c) begin
            state_q          <= ST_ISSUE;
            busy_q           <= 1'b1;
            win_q            <= win_c;
            gnt_q            <= NUM_REQ'(1) << win_c;
            write_enable_q   <= sel_we_c;
            read_enable_q    <= !sel_we_c;
            active_address_q <= sel_addr_c;
            data_in_q        <= sel_wdata_c;
          end
        end
        ST_ISSUE: begin
          if (write_enable_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_WAIT_RD;
            cnt_q   <= CNT_W'(READ_LATENCY);
          end
        end
        ST_WAIT_RD: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Last latency cycle: UART data is valid at this edge.
          if (cnt_q == CNT_W'(1)) begin
            rdata_q  <= data_out;
            rvalid_q <= NUM_REQ'(1) << win_q;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign rvalid         = rvalid_q;
  assign rdata          = rdata_q;
  assign busy           = busy_q;
  assign read_enable    = read_enable_q;
  assign write_enable   = write_enable_q;
  assign active_address = active_address_q;
  assign data_in        = data_in_q;

endmodule

// File: tb/tb_buff_uart_arbiter.sv
// Directed self-checking bench for buff_uart_arbiter (NUM_REQ=4, READ_LATENCY=2).
module tb_buff_uart_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;
  logic        read_enable;
  logic        write_enable;
  logic [3:0]  active_address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  int errors = 0;
  int checks = 0;

  buff_uart_arbiter #(
    .NUM_REQ(4), .WIDTH(8), .ADDRESS_WIDTH(4), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .read_enable(read_enable), .write_enable(write_enable),
    .active_address(active_address), .data_in(data_in), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; req_we = 4'b1111; req_addr = 16'h4321; req_wdata = 32'hFFFF_FFFF;
    data_out = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({gnt, rvalid, rdata, busy, read_enable, write_enable, active_address, data_in} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h busy=%b re=%b we=%b addr=%h din=%h want all 0",
                 gnt, rvalid, rdata, busy, read_enable, write_enable, active_address, data_in);
      end
    end
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0100; req_we = 4'b0100; req_addr = 16'h0300; req_wdata = 32'h00A5_0000;
    @(negedge clk);
    checks++;
    if ({gnt, write_enable, read_enable, active_address, data_in, rvalid} !== {4'b0100, 1'b1, 1'b0, 4'h3, 8'hA5, 4'b0000}) begin
      errors++;
      $display("FAIL wr_issue: got gnt=%b we=%b re=%b addr=%h din=%h rv=%b want 0100 1 0 3 a5 0000",
               gnt, write_enable, read_enable, active_address, data_in, rvalid);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({gnt, write_enable, busy, active_address, data_in, rvalid} !== {4'b0000, 1'b0, 1'b0, 4'h3, 8'hA5, 4'b0000}) begin
      errors++;
      $display("FAIL wr_after: got gnt=%b we=%b busy=%b addr=%h din=%h rv=%b want 0000 0 0 3 a5 0000",
               gnt, write_enable, busy, active_address, data_in, rvalid);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    data_out = 8'hEE;
    req = 4'b0010; req_we = 4'b0000; req_addr = 16'h0090;
    @(negedge clk);
    checks++;
    if ({gnt, read_enable, write_enable, active_address, rvalid} !== {4'b0010, 1'b1, 1'b0, 4'h9, 4'b0000}) begin
      errors++;
      $display("FAIL rd_issue: got gnt=%b re=%b we=%b addr=%h rv=%b want 0010 1 0 9 0000",
               gnt, read_enable, write_enable, active_address, rvalid);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({rvalid, busy, read_enable} !== {4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rd_wait1: got rv=%b busy=%b re=%b want 0000 1 0", rvalid, busy, read_enable);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL rd_wait2: got rv=%b want 0000", rvalid);
    end
    data_out = 8'h5C;
    @(negedge clk);
    data_out = 8'hEE;
    checks++;
    if ({rvalid, rdata, busy} !== {4'b0010, 8'h5C, 1'b0}) begin
      errors++;
      $display("FAIL rd_data: got rv=%b rdata=%h busy=%b want 0010 5c 0", rvalid, rdata, busy);
    end
    @(negedge clk);
    checks++;
    if ({rvalid, rdata} !== {4'b0000, 8'h5C}) begin
      errors++;
      $display("FAIL rd_hold: got rv=%b rdata=%h want 0000 5c", rvalid, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int idx;
    rst_n = 1'b0; req = 4'b1111; req_we = 4'b1111;
    req_addr = 16'h4321; req_wdata = 32'hA3A2_A1A0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      idx   = ((k - 1) / 2) % 4;
      exp_g = (k % 2 == 1) ? (4'b0001 << idx) : 4'b0000;
      checks++;
      if ({gnt, write_enable} !== {exp_g, (k % 2 == 1)}) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got gnt=%b we=%b want %b %b", k, gnt, write_enable, exp_g, (k % 2 == 1));
      end
      if (k % 2 == 1) begin
        checks++;
        if ({active_address, data_in} !== {4'(idx + 1), 8'(8'hA0 + idx)}) begin
          errors++;
          $display("FAIL rr_payload[%0d]: got addr=%h din=%h want %h %h", k, active_address, data_in,
                   4'(idx + 1), 8'(8'hA0 + idx));
        end
      end
    end
    req = '0;
  endtask

  task automatic test_two_requesters();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1001; req_we = 4'b1001; req_addr = 16'h5006; req_wdata = 32'h7700_0011;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
`ifdef BUFF_UART_ARB_FIXED_PRIO_EN
      exp_g = (k % 2 == 1) ? 4'b0001 : 4'b0000;
`else
      exp_g = (k % 2 == 0) ? 4'b0000 : ((k % 4 == 1) ? 4'b0001 : 4'b1000);
`endif
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL two_req_gnt[%0d]: got %b want %b", k, gnt, exp_g);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    data_out = 8'h99;
    req = 4'b0010; req_we = 4'b0000; req_addr = 16'h0070;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rst_rd_gnt: got %b want 0010", gnt);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({busy, active_address} !== {1'b1, 4'h7}) begin
      errors++;
      $display("FAIL rst_rd_busy: got busy=%b addr=%h want 1 7", busy, active_address);
    end
    rst_n = 1'b0;
    req = 4'b0101; req_we = 4'b0101; req_addr = 16'h0C0A; req_wdata = 32'h0033_0011;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, busy, read_enable, write_enable, active_address, data_in} !== '0) begin
      errors++;
      $display("FAIL rst_rd_clear: got gnt=%b rv=%b rd=%h busy=%b re=%b we=%b addr=%h din=%h want all 0",
               gnt, rvalid, rdata, busy, read_enable, write_enable, active_address, data_in);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, active_address, data_in} !== {4'b0001, 4'b0000, 4'hA, 8'h11}) begin
      errors++;
      $display("FAIL rst_rd_first: got gnt=%b rv=%b addr=%h din=%h want 0001 0000 a 11",
               gnt, rvalid, active_address, data_in);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_rd_norv: got %b want 0000", rvalid);
    end
  endtask

  task automatic test_withdrawn();
    do_reset();
    data_out = 8'h3C;
    req = 4'b0001; req_we = 4'b0000; req_addr = 16'h0002;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wd_gnt0: got %b want 0001", gnt);
    end
    req = 4'b0010; req_we = 4'b0010;
    @(negedge clk);
    req = '0;
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL wd_nognt[%0d]: got %b want 0000", k, gnt);
      end
      if (k == 4) begin
        checks++;
        if ({rvalid, rdata, busy} !== {4'b0001, 8'h3C, 1'b0}) begin
          errors++;
          $display("FAIL wd_rvalid: got rv=%b rdata=%h busy=%b want 0001 3c 0", rvalid, rdata, busy);
        end
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL wd_idle: got busy=%b want 0", busy);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_read();
    logic [3:0] exp_g;
    logic [3:0] exp_rv;
    do_reset();
    data_out = 8'h11;
    req = 4'b0001; req_we = 4'b0000; req_addr = 16'h0005;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_g  = (k == 1 || k == 5) ? 4'b0001 : 4'b0000;
      exp_rv = (k == 4 || k == 8) ? 4'b0001 : 4'b0000;
      checks++;
      if ({gnt, rvalid} !== {exp_g, exp_rv}) begin
        errors++;
        $display("FAIL b2b[%0d]: got gnt=%b rv=%b want %b %b", k, gnt, rvalid, exp_g, exp_rv);
      end
      if (k == 4 || k == 8) begin
        checks++;
        if (rdata !== ((k == 4) ? 8'h11 : 8'h22)) begin
          errors++;
          $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, (k == 4) ? 8'h11 : 8'h22);
        end
      end
      if (k == 4) data_out = 8'h22;
    end
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; data_out = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_two_requesters();
    test_reset_mid_read();
    test_withdrawn();
    test_back_to_back_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
